uart_rx_device: RTL

Memory-mapped UART receiver that sits on the CPU data bus beside the BCD display device and supplies `Device_Read_Data`. It samples a serial line, assembles 8N1 frames into a small RX FIFO, and lets the CPU pop bytes and read status with ordinary loads. It is the input-direction counterpart to the write-only display peripheral.

---
 rtl/uart_rx_device_pkg.sv | 19 +
 rtl/sync_fifo.sv | 53 +++++
 rtl/uart_rx_device.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_device_pkg.sv
// Shared definitions for the memory-mapped UART receiver: register offsets,
// receive FSM states and CTRL bit positions.
package uart_rx_device_pkg;

    localparam logic [31:0] RXDATA_OFF = 32'h0;
    localparam logic [31:0] STATUS_OFF = 32'h4;
    localparam logic [31:0] CTRL_OFF   = 32'h8;

    localparam int CTRL_CLR_BIT   = 0;
    localparam int CTRL_FLUSH_BIT = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with push/pop/flush and occupancy count.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)      count <= count + 1'b1;
            else if (pop_ok && !push_ok) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_rx_device.sv
// Memory-mapped 8N1 UART receiver: synchronizer, bit-rate down-counter,
// receive FSM, RX FIFO and CPU register decode.
//   state | meaning
//   IDLE  | line high, waiting for a start edge
//   START | counting to mid start bit, glitch check
//   DATA  | sampling 8 data bits, LSB first
//   STOP  | sampling stop bit; holds here after a framing error until line is high
module uart_rx_device
    import uart_rx_device_pkg::*;
#(
    parameter int          CLK_FREQ   = 100_000_000,
    parameter int          BAUD       = 115_200,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0020
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] MemBus_Address,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] MemBus_Write_Data,
    output logic [31:0] Device_Read_Data,
    input  logic        uart_rx
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT/2 - 1);
    localparam logic [CW-1:0] BIT_TC  = CW'(CLKS_PER_BIT - 1);

    logic rx_meta, rx_sync;
    rx_state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0] bit_idx, bit_nx;
    logic [7:0] shift, shift_nx;
    logic hold, hold_nx;
    logic push, frame_evt;

    logic rd_rxdata, rd_status, rd_ctrl, wr_ctrl, clr, flush, pop;
    logic overrun, frame_err, ovf_evt;
    logic [7:0] head;
    logic fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic [3:0] count4;
    logic unused_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            hold    <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_idx <= bit_nx;
            shift   <= shift_nx;
            hold    <= hold_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = (cnt != '0) ? cnt - 1'b1 : cnt;
        bit_nx    = bit_idx;
        shift_nx  = shift;
        hold_nx   = hold;
        push      = 1'b0;
        frame_evt = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_sync) begin
                    cnt_nx   = HALF_TC;
                    state_nx = START;
                end
            end
            START: begin
                if (cnt == '0) begin
                    if (!rx_sync) begin
                        state_nx = DATA;
                        cnt_nx   = BIT_TC;
                        bit_nx   = '0;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    shift_nx = {rx_sync, shift[7:1]};
                    cnt_nx   = BIT_TC;
                    if (bit_idx == 3'd7) state_nx = STOP;
                    else                 bit_nx   = bit_idx + 3'd1;
                end
            end
            STOP: begin
                // after a framing error, wait for the line to idle so a break is not re-read as a start bit
                if (hold) begin
                    if (rx_sync) begin
                        hold_nx  = 1'b0;
                        state_nx = IDLE;
                    end
                end else if (cnt == '0) begin
                    if (rx_sync) begin
                        push     = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        frame_evt = 1'b1;
                        hold_nx   = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign rd_rxdata = MemRead  && (MemBus_Address == BASE_ADDR + RXDATA_OFF);
    assign rd_status = MemRead  && (MemBus_Address == BASE_ADDR + STATUS_OFF);
    assign rd_ctrl   = MemRead  && (MemBus_Address == BASE_ADDR + CTRL_OFF);
    assign wr_ctrl   = MemWrite && (MemBus_Address == BASE_ADDR + CTRL_OFF);
    assign clr       = wr_ctrl && MemBus_Write_Data[CTRL_CLR_BIT];
    assign flush     = wr_ctrl && MemBus_Write_Data[CTRL_FLUSH_BIT];
    assign pop       = rd_rxdata;
    assign ovf_evt   = push && fifo_full && !pop && !flush;
    assign unused_wdata = ^MemBus_Write_Data[31:2];

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (shift),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // a new error in the same cycle as a clear must survive
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= (overrun   && !clr) || ovf_evt;
            frame_err <= (frame_err && !clr) || frame_evt;
        end
    end

    assign count4 = 4'(fifo_count);

    always_comb begin
        Device_Read_Data = '0;
        if (rd_rxdata && !fifo_empty) Device_Read_Data = {24'b0, head};
        else if (rd_status)           Device_Read_Data = {26'b0, overrun, frame_err, count4};
        else if (rd_ctrl)             Device_Read_Data = '0;
    end

endmodule
